retire_ctrl: RTL and testbench

Retire controller that sequences commit of the ROB head into the retire stage. Each cycle it decides whether the head may retire. Plain instructions commit in one cycle. Committed stores are held until the data-memory write handshake completes. A retiring mispredicted branch starts a fixed-length pipeline flush. It sits between the ROB head and the retire/register-file write path, and owns the store port to memory.

---
 rtl/retire_ctrl_if.sv | 40 ++++
 rtl/retire_ctrl.sv | 125 ++++++++++++
 tb/tb_retire_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/retire_ctrl_if.sv
// ROB-head, retire-write and store-port signals of the retire controller.
// The master side is the environment (ROB and memory); the slave side is retire_ctrl.
interface retire_ctrl_if #(
  parameter int unsigned COUNT_WIDTH = 32
);
  logic                   rob_head_valid;
  logic                   rob_head_complete;
  logic [4:0]             rob_head_dest;
  logic [63:0]            rob_head_value;
  logic                   rob_head_reg_valid;
  logic                   rob_head_is_store;
  logic [63:0]            rob_head_mem_addr;
  logic                   rob_head_mispredict;
  logic                   mem_ack;
  logic                   rob_retire;
  logic                   retire_valid;
  logic [4:0]             retire_dest;
  logic [63:0]            retire_value;
  logic                   mem_req;
  logic [63:0]            mem_addr;
  logic [63:0]            mem_data;
  logic                   flush;
  logic [COUNT_WIDTH-1:0] retire_count;

  modport master (
    output rob_head_valid, rob_head_complete, rob_head_dest, rob_head_value,
           rob_head_reg_valid, rob_head_is_store, rob_head_mem_addr,
           rob_head_mispredict, mem_ack,
    input  rob_retire, retire_valid, retire_dest, retire_value,
           mem_req, mem_addr, mem_data, flush, retire_count
  );

  modport slave (
    input  rob_head_valid, rob_head_complete, rob_head_dest, rob_head_value,
           rob_head_reg_valid, rob_head_is_store, rob_head_mem_addr,
           rob_head_mispredict, mem_ack,
    output rob_retire, retire_valid, retire_dest, retire_value,
           mem_req, mem_addr, mem_data, flush, retire_count
  );
endinterface

// File: rtl/retire_ctrl.sv
// Retire controller: commits the ROB head, holds stores until the memory
// write handshake completes, and raises a fixed-length flush on mispredicts.
module retire_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input logic         clock,
  input logic         reset,
  retire_ctrl_if.slave bus
);
  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic                   retire_valid_q, retire_valid_d;
  logic [4:0]             retire_dest_q, retire_dest_d;
  logic [63:0]            retire_value_q, retire_value_d;
  logic                   mem_req_q, mem_req_d;
  logic [63:0]            mem_addr_q, mem_addr_d;
  logic [63:0]            mem_data_q, mem_data_d;
  logic                   flush_q, flush_d;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   pop;
  logic                   ready;

  assign ready = bus.rob_head_valid & bus.rob_head_complete;

  always_comb begin
    state_d        = state_q;
    retire_valid_d = 1'b0;
    retire_dest_d  = '0;
    retire_value_d = '0;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    flush_d        = flush_q;
    fcnt_d         = fcnt_q;
    count_d        = count_q;
    pop            = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ready) begin
          if (bus.rob_head_is_store) begin
            mem_req_d  = 1'b1;
            mem_addr_d = bus.rob_head_mem_addr;
            mem_data_d = bus.rob_head_value;
            state_d    = ST_WAIT;
          end else begin
            pop            = 1'b1;
            count_d        = count_q + COUNT_WIDTH'(1);
            retire_valid_d = bus.rob_head_reg_valid;
            // dest/value stay zero unless a register write actually happens
            if (bus.rob_head_reg_valid) begin
              retire_dest_d  = bus.rob_head_dest;
              retire_value_d = bus.rob_head_value;
            end
            if (bus.rob_head_mispredict) begin
              flush_d = 1'b1;
              fcnt_d  = FCW'(FLUSH_CYCLES);
              state_d = FLUSH;
            end
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          pop        = 1'b1;
          count_d    = count_q + COUNT_WIDTH'(1);
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
          mem_data_d = '0;
          state_d    = RUN;
        end
      end
      FLUSH: begin
        if (fcnt_q == FCW'(1)) begin
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      retire_valid_q <= 1'b0;
      retire_dest_q  <= '0;
      retire_value_q <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      flush_q        <= 1'b0;
      fcnt_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      retire_valid_q <= retire_valid_d;
      retire_dest_q  <= retire_dest_d;
      retire_value_q <= retire_value_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      flush_q        <= flush_d;
      fcnt_q         <= fcnt_d;
      count_q        <= count_d;
    end
  end

  assign bus.rob_retire   = pop & ~reset;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_dest  = retire_dest_q;
  assign bus.retire_value = retire_value_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.flush        = flush_q;
  assign bus.retire_count = count_q;
endmodule

// File: tb/tb_retire_ctrl.sv
// Self-checking bench for retire_ctrl: vector table for single-cycle retirement,
// hand-written sequences for stores, flushes and mid-operation reset.
module tb_retire_ctrl;
  logic clock;
  logic reset;

  retire_ctrl_if #(.COUNT_WIDTH(32)) bus ();

  retire_ctrl #(.FLUSH_CYCLES(2), .COUNT_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        c;
    logic [4:0]  dest;
    logic [63:0] val;
    logic        rv;
    logic        pop;
  } vec_t;

  typedef struct {
    logic [4:0]  dest;
    logic [63:0] val;
  } wr_t;

  localparam int NV = 12;
  vec_t vt [NV];
  wr_t  sb [$];
  int   checks;
  int   errors;
  int unsigned exp_count;
  logic mon_en;

  localparam logic [63:0] A1 = 64'h8000_0040;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF;
  localparam logic [63:0] A2 = 64'h0000_1230;
  localparam logic [63:0] D2 = 64'h0BAD_F00D;
  localparam logic [63:0] A3 = 64'h0000_0FF8;
  localparam logic [63:0] D3 = 64'h1357_9BDF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic head(input logic v, input logic c, input logic [4:0] dest,
                      input logic [63:0] val, input logic rv, input logic st,
                      input logic [63:0] addr, input logic mp);
    bus.rob_head_valid      = v;
    bus.rob_head_complete   = c;
    bus.rob_head_dest       = dest;
    bus.rob_head_value      = val;
    bus.rob_head_reg_valid  = rv;
    bus.rob_head_is_store   = st;
    bus.rob_head_mem_addr   = addr;
    bus.rob_head_mispredict = mp;
  endtask

  task automatic idle();
    head(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  // One clock cycle with the inputs already driven: checks the pop pulse this
  // cycle and the registered outputs left by earlier cycles.
  task automatic cyc(input string nm, input logic pop, input logic push,
                     input logic mreq, input logic fl,
                     input logic [63:0] maddr, input logic [63:0] mdata);
    wr_t w;
    if (push) begin
      w.dest = bus.rob_head_dest;
      w.val  = bus.rob_head_value;
      sb.push_back(w);
    end
    @(negedge clock);
    chk({nm, " rob_retire"}, 64'(bus.rob_retire), 64'(pop));
    chk({nm, " retire_count"}, 64'(bus.retire_count), 64'(exp_count));
    chk({nm, " mem_req"}, 64'(bus.mem_req), 64'(mreq));
    chk({nm, " mem_addr"}, bus.mem_addr, maddr);
    chk({nm, " mem_data"}, bus.mem_data, mdata);
    chk({nm, " flush"}, 64'(bus.flush), 64'(fl));
    if (pop) exp_count++;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.retire_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got dest %0d value %h expected no write",
                   bus.retire_dest, bus.retire_value);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("write dest", 64'(bus.retire_dest), 64'(e.dest));
          chk("write value", bus.retire_value, e.val);
        end
      end else begin
        chk("idle retire_valid", 64'(bus.retire_valid), 64'(0));
        chk("idle dest", 64'(bus.retire_dest), 64'(0));
        chk("idle value", bus.retire_value, 64'h0);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 0;
    mon_en    = 1'b0;

    vt[0]  = '{1'b1, 1'b1, 5'd5, 64'h1111_1111_1111_1111, 1'b1, 1'b1};
    vt[1]  = '{1'b1, 1'b1, 5'd1, 64'h0000_0000_0000_00A1, 1'b1, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 5'd2, 64'h0000_0000_0000_00A2, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 5'd3, 64'h0000_0000_0000_00A3, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 5'd9, 64'h0000_0000_0000_0099, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 5'd7, 64'h0000_0000_0000_0077, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 5'd7, 64'h0000_0000_0000_0077, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 5'd7, 64'h0000_0000_0000_0077, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 5'd7, 64'h0000_0000_0000_0077, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 5'd7, 64'h0000_0000_0000_0077, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b1, 5'd9, 64'h0000_0000_0000_5555, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 5'd0, 64'h0000_0000_0000_0000, 1'b0, 1'b0};

    reset       = 1'b1;
    bus.mem_ack = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    for (int i = 0; i < NV; i++) begin
      head(vt[i].v, vt[i].c, vt[i].dest, vt[i].val, vt[i].rv, 1'b0, 64'h0, 1'b0);
      cyc($sformatf("vec%0d", i), vt[i].pop, vt[i].pop & vt[i].rv,
          1'b0, 1'b0, 64'h0, 64'h0);
    end

    // store with ack three cycles after mem_req rises; head stays presented
    head(1'b1, 1'b1, 5'd0, D1, 1'b0, 1'b1, A1, 1'b0);
    cyc("st_issue", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("st_wait%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, A1, D1);
    bus.mem_ack = 1'b1;
    cyc("st_ack", 1'b1, 1'b0, 1'b1, 1'b0, A1, D1);
    bus.mem_ack = 1'b0;
    idle();
    cyc("st_done", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    // ack held high: ignored in RUN, accepted in the first ST_WAIT cycle
    head(1'b1, 1'b1, 5'd0, D3, 1'b0, 1'b1, A3, 1'b0);
    bus.mem_ack = 1'b1;
    cyc("st2_issue", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    cyc("st2_ack", 1'b1, 1'b0, 1'b1, 1'b0, A3, D3);
    bus.mem_ack = 1'b0;
    idle();
    cyc("st2_done", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    // mispredicted branch writing a link register, ready head during flush
    head(1'b1, 1'b1, 5'd1, 64'h400, 1'b1, 1'b0, 64'h0, 1'b1);
    cyc("mp", 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    head(1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc("flush1", 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
    cyc("flush2", 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
    cyc("flush_end", 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
    idle();
    cyc("post_flush", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    // reset in the first flush cycle aborts the flush
    head(1'b1, 1'b1, 5'd2, 64'h800, 1'b0, 1'b0, 64'h0, 1'b1);
    cyc("mp2", 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    idle();
    reset = 1'b1;
    cyc("fl_reset", 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0);
    reset     = 1'b0;
    exp_count = 0;
    cyc("fl_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    head(1'b1, 1'b1, 5'd6, 64'h66, 1'b1, 1'b0, 64'h0, 1'b0);
    cyc("run_after_reset", 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

    // reset in the second ST_WAIT cycle drops the store
    head(1'b1, 1'b1, 5'd0, D2, 1'b0, 1'b1, A2, 1'b0);
    cyc("rs_issue", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    cyc("rs_wait1", 1'b0, 1'b0, 1'b1, 1'b0, A2, D2);
    reset = 1'b1;
    cyc("rs_wait2", 1'b0, 1'b0, 1'b1, 1'b0, A2, D2);
    reset     = 1'b0;
    exp_count = 0;
    idle();
    cyc("rs_after", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    bus.mem_ack = 1'b1;
    cyc("rs_stray_ack", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    bus.mem_ack = 1'b0;
    cyc("rs_final", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
